// File: rtl/codebook_decoder.sv
// codebook_decoder
//   Double-buffered codebook lookup. The active bank answers tag lookups
//   while the shadow bank is filled by a load stream. Once the shadow bank
//   is full, a swap exchanges the roles of the two banks.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   load_start         begin filling the shadow bank at entry 0
//   load_valid         load_data is valid this cycle
//   load_data          codeword written into the shadow bank
//   load_done          one-cycle pulse after the last shadow entry is written
//   swap               exchange active and shadow banks (honoured only when full)
//   active_bank        bank currently used for lookups
//   tag_valid/ready    tag handshake; ready = !out_valid || out_ready
//   tag                codebook index to decode
//   out_valid/ready    output handshake
//   out_data           decoded codeword
module codebook_decoder #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_done,
   input  logic              swap,
   output logic              active_bank,
   input  logic              tag_valid,
   output logic              tag_ready,
   input  logic [ADDR_W-1:0] tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic              bank_sel, bank_nxt;
   logic              done_q, done_nxt;
   logic              wr_en;
   logic              wr_bank;
   logic              accept;

   logic [DATA_W-1:0] bank_q [2][DEPTH];

   logic [DATA_W-1:0] data_p1;
   logic              vld_p1;

   // Load FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bank_sel <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bank_sel <= bank_nxt;
         done_q   <= done_nxt;
      end
   end

   // Load FSM: next state, write enable and bank swap
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bank_nxt  = bank_sel;
      done_nxt  = 1'b0;
      wr_en     = 1'b0;
      case (state)
         IDLE: begin
            if (load_start) begin
               state_nxt = LOAD;
               cnt_nxt   = '0;
            end
         end
         LOAD: begin
            // A restart wins over a same-cycle data word, which is dropped.
            if (load_start) begin
               cnt_nxt = '0;
            end else if (load_valid) begin
               wr_en   = 1'b1;
               cnt_nxt = cnt + 1'b1;
               if (cnt == ADDR_W'(DEPTH-1)) begin
                  state_nxt = FULL;
                  done_nxt  = 1'b1;
               end
            end
         end
         FULL: begin
            if (swap) begin
               bank_nxt  = ~bank_sel;
               state_nxt = IDLE;
            end
            // With a simultaneous swap the new load targets the bank that
            // was active until this edge.
            if (load_start) begin
               state_nxt = LOAD;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign wr_bank = ~bank_sel;

   // Codebook storage: per-entry registers so reset can clear every entry
   for (genvar b = 0; b < 2; b++) begin : g_bank
      for (genvar i = 0; i < DEPTH; i++) begin : g_ent
         logic [DATA_W-1:0] ent_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ent_q <= '0;
            end else if (wr_en && (wr_bank == 1'(b)) && (cnt == ADDR_W'(i))) begin
               ent_q <= load_data;
            end
         end
         assign bank_q[b][i] = ent_q;
      end
   end

   assign tag_ready = !vld_p1 || out_ready;
   assign accept    = tag_valid && tag_ready;

   // Stage p1: decoded codeword. The read uses bank_sel before the edge,
   // so a tag accepted on a swap edge decodes from the pre-swap bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         data_p1 <= bank_q[bank_sel][tag];
      end else if (out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign out_valid   = vld_p1;
   assign out_data    = data_p1;
   assign load_done   = done_q;
   assign active_bank = bank_sel;

endmodule

// File: doc/codebook_decoder.md
CODEBOOK_DECODER -- requirements
Module: codebook_decoder

Interface
REQ-001 Parameter DATA_W, default 24, codeword width in bits.
REQ-002 Parameter ADDR_W, default 6, tag width; DEPTH = 2**ADDR_W entries per bank.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load_start  input  1  pulse; begin loading shadow bank at entry 0.
REQ-006 load_valid  input  1  load_data valid this cycle.
REQ-007 load_data  input  DATA_W  codeword to write into shadow bank.
REQ-008 load_done  output  1  one-cycle pulse when shadow bank fully written.
REQ-009 swap  input  1  request exchange of active and shadow banks.
REQ-010 active_bank  output  1  index of bank currently used for lookups.
REQ-011 tag_valid  input  1  tag presented.
REQ-012 tag_ready  output  1  block can accept tag this cycle.
REQ-013 tag  input  ADDR_W  codebook index to decode.
REQ-014 out_valid  output  1  out_data holds a decoded codeword.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 out_data  output  DATA_W  decoded codeword.

Function
REQ-017 Storage SHALL be two banks of DEPTH x DATA_W; lookups read only the active bank, loads write only the shadow bank (!active_bank).
REQ-018 Load FSM states SHALL be IDLE, LOAD, FULL.
REQ-019 IDLE/FULL + load_start -> LOAD, write counter = 0; load_valid in IDLE or FULL ignored.
REQ-020 LOAD: each load_valid cycle writes load_data to shadow[counter], counter += 1.
REQ-021 LOAD: write to entry DEPTH-1 -> FULL, load_done = 1 for exactly the next cycle, counter wraps to 0.
REQ-022 load_start during LOAD SHALL restart counter at 0 (same-cycle load_valid data dropped); previously written entries retained.
REQ-023 swap SHALL be accepted only in FULL: active_bank toggles at that edge, FSM -> IDLE; swap in IDLE or LOAD ignored, no state change.
REQ-024 swap and load_start in same FULL cycle: swap executes, FSM -> LOAD targeting the new shadow bank (the former active bank).
REQ-025 Tag handshake: tag accepted when tag_valid && tag_ready; tag_ready = !out_valid || out_ready (combinational).
REQ-026 Accepted tag SHALL produce out_data = active_bank_at_accept[tag], out_valid = 1, on the next edge (latency 1).
REQ-027 A swap edge coinciding with tag acceptance SHALL decode that tag from the pre-swap bank; tags accepted on later edges use the new bank.
REQ-028 out_valid && !out_ready: out_data and out_valid SHALL hold stable; no tag accepted.
REQ-029 out_valid && out_ready with no new accept: out_valid -> 0 next edge, out_data holds last value.
REQ-030 Back-to-back accepts with out_ready held high SHALL sustain one codeword per cycle.
REQ-031 Loading the shadow bank SHALL never alter active-bank contents or in-flight out_data.

Reset
REQ-032 rst SHALL clear all entries of both banks to 0, active_bank = 0, FSM = IDLE, counter = 0, load_done = 0, out_valid = 0, out_data = 0, immediately and independent of clk.
REQ-033 rst asserted mid-load or with out_valid high SHALL abandon the operation; no partial state survives.
REQ-034 tag_ready SHALL be 1 while rst is asserted and after release (out_valid = 0).

Verification
REQ-035 After reset, tag=5 accepted, out_ready=1 -> next cycle out_valid=1, out_data=0.
REQ-036 load_start, then 64 load_valid words k*3 (k=0..63) -> load_done pulse one cycle after word 63, active_bank still 0; swap -> active_bank=1; tag=10 -> out_data=30.
REQ-037 swap during LOAD after 20 words -> ignored, active_bank unchanged, load continues to FULL on word 63.
REQ-038 out_ready=0 with out_valid=1, tag_valid=1 tag=7 held 3 cycles -> tag_ready=0, out_data stable; out_ready=1 -> tag 7 accepted, decoded next cycle.
REQ-039 Tag accepted on the same edge as swap -> decoded from old bank; tag on following edge -> new bank value.
REQ-040 rst pulse after 30 load words -> FSM IDLE, both banks read 0, active_bank=0, load_done never pulses.
